// File: rtl/mulop_mod.sv
`default_nettype none
// ============================================================================
//  Module   : mulop_mod
//  Purpose  : Iterative IDEA multiplier modulo 2^WIDTH+1. An all-zero operand
//             stands for 2^WIDTH, and a result of 2^WIDTH is returned as 0.
//             A shift-add datapath consumes one multiplier bit per cycle
//             (WIDTH+1 cycles), then a single cycle reduces the product.
//  Ports    : clk        - single clock, rising edge
//             rst        - synchronous, active-high reset
//             in_valid   - operand pair present on a/b
//             in_ready   - operands accepted (high only while idle)
//             a, b       - operands (0 encodes 2^WIDTH)
//             out_valid  - result valid, held until consumed
//             out_ready  - downstream accepts the result
//             o          - (a*b) mod (2^WIDTH+1), 2^WIDTH encoded as 0
//  Revision : 1.0 - initial release
// ============================================================================
module mulop_mod #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o
);

    // Counter must reach WIDTH, so it needs room for WIDTH+1 distinct values.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ACC_W = 2 * WIDTH + 2;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH);
    localparam logic [WIDTH+2:0] C_MOD      = (WIDTH + 3)'((64'd1 << WIDTH) + 64'd1);
    localparam logic [WIDTH:0]   C_TWO_POW  = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [WIDTH:0]      a_q,         a_d;
    logic [WIDTH:0]      b_q,         b_d;
    logic [ACC_W-1:0]    acc_q,       acc_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0]    o_q,         o_d;
    logic                out_valid_q, out_valid_d;

    // Datapath helpers
    logic [ACC_W-1:0]    w_partial;
    logic [WIDTH-1:0]    w_lo;
    logic [WIDTH+1:0]    w_hi;
    logic [WIDTH+2:0]    w_diff;
    logic [WIDTH+2:0]    w_red;

    // Multiplicand shifted into position for the current multiplier bit.
    assign w_partial = {{(WIDTH + 1){1'b0}}, a_q} << cnt_q;

    // Since 2^WIDTH == -1 (mod 2^WIDTH+1), P = hi*2^WIDTH + lo reduces to
    // lo - hi. The difference lies in [-2^WIDTH, 2^WIDTH-1]; one conditional
    // add of the modulus brings it into [1, 2^WIDTH]. Bit WIDTH+2 is the sign.
    assign w_lo   = acc_q[WIDTH-1:0];
    assign w_hi   = acc_q[ACC_W-1:WIDTH];
    assign w_diff = {3'b000, w_lo} - {1'b0, w_hi};
    assign w_red  = w_diff[WIDTH+2] ? (w_diff + C_MOD) : w_diff;

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        o_d         = o_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = (a == '0) ? C_TWO_POW : {1'b0, a};
                    b_d     = (b == '0) ? C_TWO_POW : {1'b0, b};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MUL;
                end
            end

            S_MUL: begin
                // Fixed WIDTH+1 iterations; zero multiplier bits are not skipped
                // so that latency is independent of the operands.
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + w_partial;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    state_d = S_REDUCE;
                end
            end

            S_REDUCE: begin
                // A reduced value of 2^WIDTH truncates to 0, its encoding.
                o_d         = w_red[WIDTH-1:0];
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end

            S_DONE: begin
                // No same-cycle accept: the block returns to idle first.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            o_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            o_q         <= o_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign o         = o_q;

endmodule
`default_nettype wire

// File: tb/tb_mulop_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mulop_mod
//  Purpose  : Self-checking bench for mulop_mod (WIDTH=16). Expected results
//             are pushed to a scoreboard queue when operands are accepted and
//             compared in order when the DUT hands a result downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mulop_mod;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] exp_q[$];

    mulop_mod #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the whole run is far shorter than this.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        longint unsigned xx;
        longint unsigned yy;
        xx = (x == 0) ? 64'd65536 : 64'(x);
        yy = (y == 0) ? 64'd65536 : 64'(y);
        return WIDTH'((xx * yy) % 64'd65537);
    endfunction

    // Scoreboard: inputs are driven 1 time unit after a rising edge, so the
    // values seen at the falling edge are exactly what the next edge samples.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_mul(a, b));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'(o), 32'hFFFF_FFFF);
                end else begin
                    chk("result", 32'(o), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until idle, then present one operand pair for one edge.
    task automatic issue(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input bit rnd);
        int k;
        k = 0;
        while (!in_ready && k < 200) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            step();
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        step();
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid rises (bounded).
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb);
        int n;
        issue(xa, xb, 1'b0);
        out_ready = 1'b1;
        wait_out(n);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] bp_exp;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_o",         32'(o),         32'd0);

        // Latency and handshake timing with 3*5.
        issue(16'd3, 16'd5, 1'b0);
        chk("in_ready_drop", 32'(in_ready), 32'd0);
        wait_out(n);
        chk("latency", 32'(n), 32'd18);
        chk("o_3x5", 32'(o), 32'd15);
        step();
        chk("in_ready_back", 32'(in_ready), 32'd1);
        chk("out_valid_clear", 32'(out_valid), 32'd0);

        // Boundary operands: zero encodings and the top of the range.
        run_op(16'h0000, 16'h0000);
        run_op(16'h0000, 16'h0001);
        run_op(16'h0002, 16'h0000);
        run_op(16'hFFFF, 16'hFFFF);
        run_op(16'h8000, 16'h0002);
        run_op(16'h0001, 16'h0001);
        run_op(16'h1234, 16'hABCD);

        // Backpressure: result held, new operands ignored.
        out_ready = 1'b0;
        issue(16'h1234, 16'h5678, 1'b0);
        bp_exp = ref_mul(16'h1234, 16'h5678);
        wait_out(n);
        in_valid = 1'b1;
        a        = 16'h0BAD;
        b        = 16'h0F00;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_o",         32'(o),         32'(bp_exp));
            chk("bp_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        run_op(16'h00AA, 16'h0101);

        // Reset in the middle of the multiply loop (counter at 7).
        issue(16'h4321, 16'h8765, 1'b0);
        for (int i = 0; i < 7; i++) step();
        do_reset();
        chk("rst_mul_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mul_in_ready",  32'(in_ready),  32'd1);
        chk("rst_mul_o",         32'(o),         32'd0);
        run_op(16'd7, 16'd9);
        chk("after_rst_mul_o", 32'(o), 32'd63);

        // Reset while a result is waiting in DONE.
        out_ready = 1'b0;
        issue(16'h2222, 16'h3333, 1'b0);
        wait_out(n);
        step();
        do_reset();
        chk("rst_done_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done_in_ready",  32'(in_ready),  32'd1);
        chk("rst_done_o",         32'(o),         32'd0);
        out_ready = 1'b1;
        run_op(16'd7, 16'd9);
        chk("after_rst_done_o", 32'(o), 32'd63);

        // Randomized sweep with random downstream stalls.
        for (int i = 0; i < 2000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(0, 15))
                0: ra = '0;
                1: rb = '0;
                2: ra = '1;
                3: rb = '1;
                default: ;
            endcase
            issue(ra, rb, 1'b1);
        end
        // Drain the last result.
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
